parity_check_sched: RTL and testbench

//  Round-robin scheduler that shares one DW-bit XOR-reduction parity unit among NREQ requesters.

---
 rtl/parity_sched_pkg.sv | 37 +++
 rtl/parity_check_sched_tree.sv | 38 +++
 rtl/parity_check_sched.sv | 162 ++++++++++++++++
 tb/tb_parity_check_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : parity_sched_pkg
//  Brief    : Shared types and the round-robin pick helper for the parity
//             check scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package parity_sched_pkg;

  // Upper bound on requester count supported by rr_pick
  localparam int unsigned MAX_NREQ = 32;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Returns the first valid index strictly after 'last', wrapping modulo nreq.
  // The previously granted index is checked last, which makes it lowest priority.
  // If nothing is valid the result is 'last' and the caller must ignore it.
  function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] valid,
                                          input int unsigned         last,
                                          input int unsigned         nreq);
    int unsigned idx;
    rr_pick = last;
    // Walk from the farthest distance down so the nearest valid index wins.
    for (int unsigned k = MAX_NREQ; k >= 1; k--) begin
      idx = last + k;
      if (idx >= nreq) idx = idx - nreq;
      if ((k <= nreq) && valid[idx[MAX_IDX_W-1:0]]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_check_sched_tree.sv
`default_nettype none
// ============================================================================
//  Module   : parity_tree
//  Brief    : Combinational balanced XOR reduction of a DW-bit word.
//             Leaves are padded to a power of two with zeros; node k of the
//             heap-ordered array is the XOR of its two children.
//  Revision : 1.0 - initial release
// ============================================================================
module parity_tree #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] data,
  output logic          par
);

  localparam int LVL = (DW > 1) ? $clog2(DW) : 0;
  localparam int P2  = 1 << LVL;

  logic [2*P2-2:0] w_node;

  // Leaves occupy the last P2 heap slots
  for (genvar j = 0; j < P2; j++) begin : g_leaf
    if (j < DW) begin : g_data
      assign w_node[P2-1+j] = data[j];
    end else begin : g_pad
      assign w_node[P2-1+j] = 1'b0;
    end
  end

  // Internal nodes combine pairs, giving a log2(DW)-deep tree
  for (genvar k = 0; k < P2-1; k++) begin : g_node
    assign w_node[k] = w_node[2*k+1] ^ w_node[2*k+2];
  end

  assign par = w_node[0];

endmodule
`default_nettype wire

// File: rtl/parity_check_sched.sv
`default_nettype none
// ============================================================================
//  Module   : parity_check_sched
//  Brief    : Round-robin scheduler sharing one parity tree among NREQ
//             requesters. One request in flight at a time: IDLE grants and
//             captures, CALC evaluates and registers the response, HOLD waits
//             for the consumer.
//  Config   : PARITY_ERR_CNT_EN - adds per-requester saturating mismatch
//             counters (err_cnt) with a synchronous clear (err_cnt_clr).
//  Revision : 1.0 - initial release
// ============================================================================
module parity_check_sched
  import parity_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DW    = 16,
  parameter  int CNT_W = 8,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_exp,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_parity,
  output logic               rsp_err,
  output logic               busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [NREQ*CNT_W-1:0] err_cnt,
  input  logic                  err_cnt_clr
`endif
);

  // Reject configurations the pick helper or counters cannot represent
  if ((NREQ < 2) || (NREQ > int'(MAX_NREQ)) || (DW < 1) || (CNT_W < 1)) begin : g_param_check
    $error("parity_check_sched: unsupported parameter set");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic [ID_W-1:0]       r_last_grant;
  logic [ID_W-1:0]       w_grant;
  logic [ID_W-1:0]       r_id;
  logic [DW-1:0]         r_data;
  logic                  r_exp;
  logic [DW-1:0]         w_sel_data;
  logic                  w_sel_exp;
  logic                  w_take;
  logic                  w_accept;
  logic                  w_par;
  logic [MAX_NREQ-1:0]   w_valid_ext;

  // Widen the valid vector to the helper's fixed width
  always_comb begin
    w_valid_ext              = '0;
    w_valid_ext[NREQ-1:0]    = req_valid;
  end

  assign w_grant  = ID_W'(rr_pick(w_valid_ext, 32'(r_last_grant), 32'(NREQ)));
  // The picked index is always a valid one when any request is present
  assign w_take   = (r_state == IDLE) && !rst && (|req_valid);
  assign w_accept = (r_state == HOLD) && rsp_valid && rsp_ready;

  // Select the granted requester's word and expected parity
  always_comb begin
    w_sel_data = '0;
    w_sel_exp  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_sel_data = req_data[i*DW +: DW];
        w_sel_exp  = req_exp[i];
      end
    end
  end

  parity_tree #(
    .DW (DW)
  ) u_tree (
    .data (r_data),
    .par  (w_par)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_take)   w_next_state = CALC;
      CALC:                  w_next_state = HOLD;
      HOLD:    if (w_accept) w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  // Handshake outputs: one-hot ready only in IDLE with a pending request
  always_comb begin
    busy      = (r_state != IDLE);
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_take && (w_grant == ID_W'(i));
    end
  end

  // Capture on grant, register the response in CALC, retire it on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ID_W'(NREQ - 1);
      r_id         <= '0;
      r_data       <= '0;
      r_exp        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_parity   <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (w_take) begin
        r_last_grant <= w_grant;
        r_id         <= w_grant;
        r_data       <= w_sel_data;
        r_exp        <= w_sel_exp;
      end
      if (r_state == CALC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= r_id;
        rsp_parity <= w_par;
        rsp_err    <= w_par ^ r_exp;
      end
      if (w_accept) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Saturating per-requester mismatch counters; clear beats increment
  for (genvar g = 0; g < NREQ; g++) begin : g_err_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst || err_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_accept && rsp_err && (rsp_id == ID_W'(g)) && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign err_cnt[g*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_check_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parity_check_sched
//  Brief    : Directed self-checking bench for parity_check_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parity_check_sched;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_exp;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_parity;
  logic               rsp_err;
  logic               busy;
`ifdef PARITY_ERR_CNT_EN
  logic [NREQ*CNT_W-1:0] err_cnt;
  logic                  err_cnt_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_check_sched #(
    .NREQ  (NREQ),
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_exp    (req_exp),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_parity (rsp_parity),
    .rsp_err    (rsp_err),
    .busy       (busy)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt),
    .err_cnt_clr (err_cnt_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a single-requester transaction and step to the HOLD cycle
  task automatic issue(input int id, input logic [DW-1:0] d, input logic e);
    req_valid              = '0;
    req_valid[id]          = 1'b1;
    req_data[id*DW +: DW]  = d;
    req_exp[id]            = e;
    tick();          // handshake edge
    req_valid = '0;
    tick();          // CALC -> HOLD
  endtask

  // Accept the held response, optionally clearing counters in the same cycle
  task automatic accept(input logic clr);
    rsp_ready = 1'b1;
`ifdef PARITY_ERR_CNT_EN
    err_cnt_clr = clr;
`else
    if (clr) rsp_ready = 1'b1;
`endif
    tick();
    rsp_ready = 1'b0;
`ifdef PARITY_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Contention data: parities 0,1,0,1 with expected parity all zero
  logic [DW-1:0] c_words [NREQ] = '{16'h0003, 16'h0007, 16'h00FF, 16'h8000};
  logic          c_par   [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_exp   = '0;
    rsp_ready = 1'b0;
`ifdef PARITY_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif

    // 1. Reset with every requester valid
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_par", 32'(rsp_parity), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // 2. Single request from requester 2
    req_valid     = 4'b0100;
    req_data[2*DW +: DW] = 16'h0001;
    req_exp[2]    = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("single_calc_valid", 32'(rsp_valid), 32'h0);
    check("single_calc_busy", 32'(busy), 32'h1);
    tick();
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_id", 32'(rsp_id), 32'h2);
    check("single_par", 32'(rsp_parity), 32'h1);
    check("single_err", 32'(rsp_err), 32'h0);
    accept(1'b0);
    check("single_done_valid", 32'(rsp_valid), 32'h0);
    check("single_done_busy", 32'(busy), 32'h0);

    // 3. Contention from a fresh pointer: order 0,1,2,3,0
    do_reset(1);
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = c_words[i];
    req_exp   = '0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("cont_ready", 32'(req_ready), 32'(1 << order[g]));
      tick();
      check("cont_calc_ready", 32'(req_ready), 32'h0);
      tick();
      check("cont_id", 32'(rsp_id), 32'(order[g]));
      check("cont_par", 32'(rsp_parity), 32'(c_par[order[g]]));
      check("cont_err", 32'(rsp_err), 32'(c_par[order[g]]));
      check("cont_hold_ready", 32'(req_ready), 32'h0);
      tick();
    end

    // 4. Backpressure: requester 1 held five cycles in HOLD
    rsp_ready = 1'b0;
    #1;
    check("bp_ready", 32'(req_ready), 32'h2);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_id", 32'(rsp_id), 32'h1);
      check("bp_par", 32'(rsp_parity), 32'h1);
      check("bp_err", 32'(rsp_err), 32'h1);
      check("bp_no_grant", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_next_ready", 32'(req_ready), 32'h4);
    tick();
    check("bp_next_calc", 32'(rsp_valid), 32'h0);
    tick();
    check("bp_next_id", 32'(rsp_id), 32'h2);
    req_valid = '0;
    tick();
    rsp_ready = 1'b0;

    // 5. Mismatch detection (counters when enabled)
    do_reset(1);
    issue(1, 16'hFFFF, 1'b1);
    check("mm_id", 32'(rsp_id), 32'h1);
    check("mm_par", 32'(rsp_parity), 32'h0);
    check("mm_err", 32'(rsp_err), 32'h1);
    accept(1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("cnt_one", 32'(err_cnt[1*CNT_W +: CNT_W]), 32'h1);
`endif
    issue(3, 16'hA5A4, 1'b0);
    check("mm2_par", 32'(rsp_parity), 32'h1);
    check("mm2_err", 32'(rsp_err), 32'h1);
    accept(1'b0);
`ifdef PARITY_ERR_CNT_EN
    for (int n = 1; n < 300; n++) begin
      issue(1, 16'hFFFF, 1'b1);
      accept(1'b0);
    end
    check("cnt_sat", 32'(err_cnt[1*CNT_W +: CNT_W]), 32'hFF);
    check("cnt_other", 32'(err_cnt[0*CNT_W +: CNT_W]), 32'h0);
    check("cnt_req3", 32'(err_cnt[3*CNT_W +: CNT_W]), 32'h1);
    issue(1, 16'hFFFF, 1'b1);
    accept(1'b1);
    check("cnt_clr", 32'(err_cnt[1*CNT_W +: CNT_W]), 32'h0);
`endif

    // 6. Reset while in CALC drops the transaction
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = 16'h0001;
    req_exp[3] = 1'b1;
    tick();
    req_valid = '0;
    check("mid_calc_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b1;
    tick();
    check("mid_no_rsp", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("mid_prio0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check("mid_valid", 32'(rsp_valid), 32'h1);
    check("mid_id", 32'(rsp_id), 32'h0);
    check("mid_par", 32'(rsp_parity), 32'h0);
    accept(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
